reg_file_wb: RTL and testbench

Register file and writeback collector for the SPU: 128 × 128-bit registers, written by the execution pipes' writeback ports (FP6 `rt_wb` and FP7 `rt_int` buses) and read by the RF/FWD stage to supply `ra`/`rb`/`rc`. It includes a per-register latency scoreboard so the issue stage stalls on RAW and out-of-order WAW hazards instead of reading stale operands. Read ports are combinational, with same-cycle writeback bypass.

---
 rtl/spu_pkg.sv | 28 ++
 rtl/reg_scoreboard.sv | 58 +++++
 rtl/reg_file_wb.sv | 99 +++++++++
 tb/tb_reg_file_wb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared SPU definitions: register file geometry, pipe latencies and
// the operand/address types used by the execution pipes and writeback.
package spu_pkg;

    localparam int REG_ADDR_W = 7;
    localparam int REG_W      = 128;
    localparam int SPU_NREGS  = 1 << REG_ADDR_W;
    localparam int SPU_LAT_W  = 3;

    localparam logic [SPU_LAT_W-1:0] LAT_FP6 = 3'd6;
    localparam logic [SPU_LAT_W-1:0] LAT_FP7 = 3'd7;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_val_t;
    typedef logic [SPU_LAT_W-1:0]  lat_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_val_t  data;
    } wb_port_t;

    // True when a writeback port carries a result for the given register.
    function automatic logic wb_hits(input wb_port_t port, input reg_addr_t addr);
        return port.valid && (port.addr == addr);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register latency scoreboard: counts down outstanding results and
// stalls issue on RAW and out-of-order WAW hazards.
module reg_scoreboard #(
    parameter int NREGS  = spu_pkg::SPU_NREGS,
    parameter int ADDR_W = spu_pkg::REG_ADDR_W,
    parameter int LAT_W  = spu_pkg::SPU_LAT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] rc_addr,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rt_addr,
    input  logic              issue_reg_write,
    input  logic [LAT_W-1:0]  issue_lat,
    output logic              stall
);
    import spu_pkg::*;

    logic [LAT_W-1:0] r_cnt [NREGS];

    logic w_raw;
    logic w_waw;
    logic w_stall;
    logic w_load;

    // A count of 1 means the result lands this cycle and is bypassed, so
    // only counts of 2 or more block a read.
    always_comb begin
        w_raw   = (r_cnt[ra_addr] >= LAT_W'(2)) ||
                  (r_cnt[rb_addr] >= LAT_W'(2)) ||
                  (r_cnt[rc_addr] >= LAT_W'(2));
        w_waw   = issue_reg_write && (r_cnt[issue_rt_addr] > issue_lat);
        w_stall = issue_valid && (w_raw || w_waw);
        w_load  = issue_valid && !w_stall && issue_reg_write &&
                  (issue_lat != '0);
    end

    assign stall = w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_load && (issue_rt_addr == ADDR_W'(i))) begin
                    r_cnt[i] <= issue_lat;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - LAT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// SPU register file with FP6/FP7 writeback collection, same-cycle read
// bypass and a latency scoreboard gating instruction issue.
module reg_file_wb #(
    parameter int NREGS  = spu_pkg::SPU_NREGS,
    parameter int REG_W  = spu_pkg::REG_W,
    parameter int ADDR_W = spu_pkg::REG_ADDR_W,
    parameter int LAT_W  = spu_pkg::SPU_LAT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] rc_addr,
    output logic [REG_W-1:0]  ra,
    output logic [REG_W-1:0]  rb,
    output logic [REG_W-1:0]  rc,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rt_addr,
    input  logic              issue_reg_write,
    input  logic [LAT_W-1:0]  issue_lat,
    output logic              issue_ready,
    input  logic [REG_W-1:0]  rt_wb,
    input  logic [ADDR_W-1:0] rt_addr_wb,
    input  logic              reg_write_wb,
    input  logic [REG_W-1:0]  rt_int,
    input  logic [ADDR_W-1:0] rt_addr_int,
    input  logic              reg_write_int
);
    import spu_pkg::*;

    logic [REG_W-1:0] r_regs [NREGS];

    wb_port_t         w_fp6;
    wb_port_t         w_fp7;
    logic [ADDR_W-1:0] w_rd_addr [3];
    logic [REG_W-1:0]  w_rd_data [3];
    logic              w_stall;

    assign w_fp6 = '{valid: reg_write_wb,  addr: reg_addr_t'(rt_addr_wb),  data: reg_val_t'(rt_wb)};
    assign w_fp7 = '{valid: reg_write_int, addr: reg_addr_t'(rt_addr_int), data: reg_val_t'(rt_int)};

    // FP7 is written first so a same-address FP6 result (the younger
    // instruction) takes precedence.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (reg_write_int) begin
                r_regs[rt_addr_int] <= rt_int;
            end
            if (reg_write_wb) begin
                r_regs[rt_addr_wb] <= rt_wb;
            end
        end
    end

    assign w_rd_addr[0] = ra_addr;
    assign w_rd_addr[1] = rb_addr;
    assign w_rd_addr[2] = rc_addr;

    // Read ports see a writeback in the same cycle it is presented, with
    // the same FP6-over-FP7 priority as the array write.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rd_data[p] = r_regs[w_rd_addr[p]];
            if (wb_hits(w_fp6, reg_addr_t'(w_rd_addr[p]))) begin
                w_rd_data[p] = rt_wb;
            end else if (wb_hits(w_fp7, reg_addr_t'(w_rd_addr[p]))) begin
                w_rd_data[p] = rt_int;
            end
        end
    end

    assign ra = w_rd_data[0];
    assign rb = w_rd_data[1];
    assign rc = w_rd_data[2];

    reg_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .LAT_W  (LAT_W)
    ) u_scoreboard (
        .clk             (clk),
        .reset           (reset),
        .ra_addr         (ra_addr),
        .rb_addr         (rb_addr),
        .rc_addr         (rc_addr),
        .issue_valid     (issue_valid),
        .issue_rt_addr   (issue_rt_addr),
        .issue_reg_write (issue_reg_write),
        .issue_lat       (issue_lat),
        .stall           (w_stall)
    );

    assign issue_ready = !w_stall;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: a cycle-level model tracks register
// contents and result arrival cycles and is compared on every negedge.
module tb_reg_file_wb;

    localparam int NR = 128;
    localparam int RW = 128;
    localparam int AW = 7;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] raAddr, rbAddr, rcAddr;
    logic [RW-1:0] ra, rb, rc;
    logic          issueValid;
    logic [AW-1:0] issueRtAddr;
    logic          issueRegWrite;
    logic [LW-1:0] issueLat;
    logic          issueReady;
    logic [RW-1:0] rtWb, rtInt;
    logic [AW-1:0] rtAddrWb, rtAddrInt;
    logic          regWriteWb, regWriteInt;

    int checks = 0;
    int errors = 0;
    logic checkEn = 1'b0;

    reg_file_wb dut (
        .clk             (clk),
        .reset           (reset),
        .ra_addr         (raAddr),
        .rb_addr         (rbAddr),
        .rc_addr         (rcAddr),
        .ra              (ra),
        .rb              (rb),
        .rc              (rc),
        .issue_valid     (issueValid),
        .issue_rt_addr   (issueRtAddr),
        .issue_reg_write (issueRegWrite),
        .issue_lat       (issueLat),
        .issue_ready     (issueReady),
        .rt_wb           (rtWb),
        .rt_addr_wb      (rtAddrWb),
        .reg_write_wb    (regWriteWb),
        .rt_int          (rtInt),
        .rt_addr_int     (rtAddrInt),
        .reg_write_int   (regWriteInt)
    );

    always #5 clk = ~clk;

    // Model: register contents plus the absolute cycle in which each
    // pending result is due to arrive on a writeback port.
    logic [RW-1:0] modelMem [NR];
    int            dueCycle [NR];
    int            cyc = 0;
    logic          modelAccept;

    function automatic int remaining(input logic [AW-1:0] r);
        return (dueCycle[r] >= cyc) ? (dueCycle[r] - cyc + 1) : 0;
    endfunction

    function automatic logic modelStall();
        if (!issueValid) return 1'b0;
        if (remaining(raAddr) >= 2 || remaining(rbAddr) >= 2 || remaining(rcAddr) >= 2) return 1'b1;
        if (issueRegWrite && remaining(issueRtAddr) > int'(issueLat)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [RW-1:0] modelRead(input logic [AW-1:0] a);
        if (regWriteWb && rtAddrWb == a) return rtWb;
        if (regWriteInt && rtAddrInt == a) return rtInt;
        return modelMem[a];
    endfunction

    always @(posedge clk) begin
        modelAccept = issueValid && !modelStall();
        cyc = cyc + 1;
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                modelMem[r] = '0;
                dueCycle[r] = -1;
            end
        end else begin
            if (modelAccept && issueRegWrite && issueLat != 0)
                dueCycle[issueRtAddr] = cyc + int'(issueLat) - 1;
            if (regWriteInt) modelMem[rtAddrInt] = rtInt;
            if (regWriteWb)  modelMem[rtAddrWb]  = rtWb;
        end
    end

    task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_ra", ra, modelRead(raAddr));
            checkOutput("model_rb", rb, modelRead(rbAddr));
            checkOutput("model_rc", rc, modelRead(rcAddr));
            checkBit("model_issue_ready", issueReady, !modelStall());
        end
    end

    task automatic applyIdle();
        raAddr = '0; rbAddr = '0; rcAddr = '0;
        issueValid = 1'b0; issueRtAddr = '0; issueRegWrite = 1'b0; issueLat = '0;
        rtWb = '0; rtAddrWb = '0; regWriteWb = 1'b0;
        rtInt = '0; rtAddrInt = '0; regWriteInt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        int stallCycles;
        logic released;

        // Reset state
        raAddr = 7'd0; rbAddr = 7'd5; rcAddr = 7'd127;
        #2;
        checkOutput("rst_r0", ra, '0);
        checkOutput("rst_r5", rb, '0);
        checkOutput("rst_r127", rc, '0);
        checkBit("rst_ready_idle", issueReady, 1'b1);
        issueValid = 1'b1; issueRtAddr = 7'd1;
        #1;
        checkBit("rst_ready_valid", issueReady, 1'b1);
        tick();

        // Same-cycle bypass on both ports, then array readback
        applyIdle();
        regWriteWb = 1'b1; rtAddrWb = 7'd10; rtWb = {8{16'hAAAA}}; raAddr = 7'd10;
        regWriteInt = 1'b1; rtAddrInt = 7'd11; rtInt = {8{16'h5555}}; rbAddr = 7'd11;
        #2;
        checkOutput("bypass_fp6", ra, {8{16'hAAAA}});
        checkOutput("bypass_fp7", rb, {8{16'h5555}});
        tick();
        applyIdle();
        raAddr = 7'd10; rbAddr = 7'd11;
        #2;
        checkOutput("array_r10", ra, {8{16'hAAAA}});
        checkOutput("array_r11", rb, {8{16'h5555}});
        tick();

        // Both ports write r3: FP6 wins in bypass and array
        applyIdle();
        regWriteWb = 1'b1; rtAddrWb = 7'd3; rtWb = 128'h1;
        regWriteInt = 1'b1; rtAddrInt = 7'd3; rtInt = 128'h2;
        rcAddr = 7'd3;
        #2;
        checkOutput("prio_bypass_r3", rc, 128'h1);
        tick();
        applyIdle();
        rcAddr = 7'd3;
        #2;
        checkOutput("prio_array_r3", rc, 128'h1);
        tick();

        // Latency 0 leaves no scoreboard entry
        applyIdle();
        issueValid = 1'b1; issueRtAddr = 7'd30; issueRegWrite = 1'b1; issueLat = 3'd0;
        tick();
        applyIdle();
        issueValid = 1'b1; raAddr = 7'd30; rbAddr = 7'd30; rcAddr = 7'd30;
        #2;
        checkBit("lat0_no_stall", issueReady, 1'b1);
        tick();

        // RAW: issue r20 L=6, one idle cycle, then a reader of r20
        applyIdle();
        issueValid = 1'b1; issueRtAddr = 7'd20; issueRegWrite = 1'b1; issueLat = 3'd6;
        #2;
        checkBit("raw_issue_ready", issueReady, 1'b1);
        tick();
        applyIdle();
        tick();
        applyIdle();
        issueValid = 1'b1; raAddr = 7'd20; rbAddr = 7'd20; rcAddr = 7'd20;
        stallCycles = 0;
        released = 1'b0;
        for (int i = 0; i < 8 && !released; i++) begin
            regWriteWb = (i == 4); rtAddrWb = 7'd20; rtWb = 128'hDEAD;
            #2;
            if (issueReady) begin
                released = 1'b1;
                checkOutput("raw_release_ra", ra, 128'hDEAD);
            end else begin
                stallCycles++;
                checkOutput("raw_stall_ra", ra, '0);
            end
            tick();
        end
        checkBit("raw_released", released, 1'b1);
        checkOutput("raw_stall_count", RW'(stallCycles), RW'(4));
        applyIdle();
        raAddr = 7'd20;
        #2;
        checkOutput("raw_array_r20", ra, 128'hDEAD);
        tick();

        // WAW: r7 L=7, then r7 L=1 must wait until cnt[r7] <= 1
        applyIdle();
        issueValid = 1'b1; issueRtAddr = 7'd7; issueRegWrite = 1'b1; issueLat = 3'd7;
        tick();
        issueLat = 3'd1;
        stallCycles = 0;
        released = 1'b0;
        for (int i = 0; i < 10 && !released; i++) begin
            regWriteInt = (i == 6); rtAddrInt = 7'd7; rtInt = 128'h77;
            #2;
            if (issueReady) released = 1'b1;
            else stallCycles++;
            tick();
        end
        checkBit("waw_released", released, 1'b1);
        checkOutput("waw_stall_count", RW'(stallCycles), RW'(6));
        applyIdle();
        regWriteWb = 1'b1; rtAddrWb = 7'd7; rtWb = 128'h71;
        issueValid = 1'b1; raAddr = 7'd7; rbAddr = 7'd7; rcAddr = 7'd7;
        #2;
        checkBit("waw_cnt1_ready", issueReady, 1'b1);
        checkOutput("waw_young_bypass", ra, 128'h71);
        tick();
        applyIdle();
        raAddr = 7'd7;
        #2;
        checkOutput("waw_array_r7", ra, 128'h71);
        tick();

        // Reset mid-operation drops the pending r9 entry
        applyIdle();
        regWriteWb = 1'b1; rtAddrWb = 7'd9; rtWb = 128'h99;
        tick();
        applyIdle();
        issueValid = 1'b1; issueRtAddr = 7'd9; issueRegWrite = 1'b1; issueLat = 3'd7;
        raAddr = 7'd9;
        #2;
        checkOutput("pre_reset_r9", ra, 128'h99);
        tick();
        applyIdle();
        issueValid = 1'b1; raAddr = 7'd9; rbAddr = 7'd9; rcAddr = 7'd9;
        #2;
        checkBit("pre_reset_stall", issueReady, 1'b0);
        tick();
        applyIdle();
        reset = 1'b1;
        regWriteWb = 1'b1; rtAddrWb = 7'd9; rtWb = 128'h5;
        tick();
        reset = 1'b0;
        applyIdle();
        issueValid = 1'b1; raAddr = 7'd9; rbAddr = 7'd9; rcAddr = 7'd9;
        #2;
        checkBit("post_reset_ready", issueReady, 1'b1);
        checkOutput("post_reset_r9", ra, '0);
        tick();
        applyIdle();
        regWriteInt = 1'b1; rtAddrInt = 7'd9; rtInt = 128'h1234;
        tick();
        applyIdle();
        raAddr = 7'd9;
        #2;
        checkOutput("late_wb_r9", ra, 128'h1234);
        tick();
        applyIdle();
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            modelMem[r] = '0;
            dueCycle[r] = -1;
        end
        applyIdle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkEn = 1'b1;
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
